// File: rtl/vector_dot_reducer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vector_dot_reducer_pkg
// Brief   : Shared state encoding and width helpers for the dot-product path.
// Revision: 1.0 - initial release
// ============================================================================
package vector_dot_reducer_pkg;

    localparam logic [1:0] c_STATE_IDLE  = 2'd0;
    localparam logic [1:0] c_STATE_ACCUM = 2'd1;
    localparam logic [1:0] c_STATE_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = c_STATE_IDLE,
        ST_ACCUM = c_STATE_ACCUM,
        ST_HOLD  = c_STATE_HOLD
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // The sum of VECTOR_SIZE full-scale elements must fit without wrapping.
    function automatic bit acc_width_ok(input int data_width, input int vector_size,
                                        input int acc_width);
        return acc_width >= (data_width + clog2(vector_size));
    endfunction

endpackage
`default_nettype wire

// File: rtl/vector_dot_reducer.sv
`default_nettype none
// ============================================================================
// Module  : vector_dot_reducer
// Brief   : Serially sums a captured product vector into a scalar presented on
//           a valid/ready output, with a one-entry pending buffer and sticky
//           overflow flag for vectors that cannot be absorbed.
// Revision: 1.0 - initial release
// ============================================================================
module vector_dot_reducer
    import vector_dot_reducer_pkg::*;
#(
    parameter int VECTOR_SIZE = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 19
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] in_vector,
    output logic [ACC_WIDTH-1:0]              out_sum,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy,
    output logic                              overflow,
    input  logic                              clear_overflow
);

    localparam int c_VEC_W = DATA_WIDTH * VECTOR_SIZE;
    localparam int c_IDX_W = (VECTOR_SIZE > 1) ? clog2(VECTOR_SIZE) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(VECTOR_SIZE - 1);

    generate
        if (!acc_width_ok(DATA_WIDTH, VECTOR_SIZE, ACC_WIDTH)) begin : g_acc_width_check
            $error("ACC_WIDTH too narrow for DATA_WIDTH and VECTOR_SIZE");
        end
    endgenerate

    state_e                 r_state_q,     w_state_d;
    logic [c_VEC_W-1:0]     r_work_q,      w_work_d;
    logic [c_VEC_W-1:0]     r_pend_q,      w_pend_d;
    logic                   r_pend_vld_q,  w_pend_vld_d;
    logic [c_IDX_W-1:0]     r_idx_q,       w_idx_d;
    logic [ACC_WIDTH-1:0]   r_acc_q,       w_acc_d;
    logic [ACC_WIDTH-1:0]   r_out_sum_q,   w_out_sum_d;
    logic                   r_out_valid_q, w_out_valid_d;
    logic                   r_overflow_q,  w_overflow_d;

    logic [ACC_WIDTH-1:0]   w_elem_ext;
    logic [ACC_WIDTH-1:0]   w_acc_next;
    logic                   w_handshake;
    logic                   w_park;
    logic                   w_drop;

    always_comb begin
        w_state_d     = r_state_q;
        w_work_d      = r_work_q;
        w_pend_d      = r_pend_q;
        w_pend_vld_d  = r_pend_vld_q;
        w_idx_d       = r_idx_q;
        w_acc_d       = r_acc_q;
        w_out_sum_d   = r_out_sum_q;
        w_out_valid_d = r_out_valid_q;
        w_overflow_d  = r_overflow_q;
        w_park        = 1'b0;
        w_drop        = 1'b0;

        w_elem_ext  = ACC_WIDTH'(r_work_q[r_idx_q*DATA_WIDTH +: DATA_WIDTH]);
        w_acc_next  = r_acc_q + w_elem_ext;
        w_handshake = r_out_valid_q && out_ready;

        case (r_state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_work_d  = in_vector;
                    w_idx_d   = '0;
                    w_acc_d   = '0;
                    w_state_d = ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                w_park = in_valid;
                if (r_idx_q == c_IDX_LAST) begin
                    w_out_sum_d   = w_acc_next;
                    w_out_valid_d = 1'b1;
                    w_state_d     = ST_HOLD;
                end else begin
                    w_acc_d = w_acc_next;
                    w_idx_d = r_idx_q + c_IDX_W'(1);
                end
            end

            ST_HOLD: begin
                if (w_handshake) begin
                    w_out_valid_d = 1'b0;
                    w_idx_d       = '0;
                    w_acc_d       = '0;
                    if (r_pend_vld_q) begin
                        // Pending drains first; a same-cycle arrival refills the slot.
                        w_work_d     = r_pend_q;
                        w_pend_vld_d = in_valid;
                        if (in_valid) begin
                            w_pend_d = in_vector;
                        end
                        w_state_d = ST_ACCUM;
                    end else if (in_valid) begin
                        w_work_d  = in_vector;
                        w_state_d = ST_ACCUM;
                    end else begin
                        w_state_d = ST_IDLE;
                    end
                end else begin
                    w_park = in_valid;
                end
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        if (w_park) begin
            if (!r_pend_vld_q) begin
                w_pend_vld_d = 1'b1;
                w_pend_d     = in_vector;
            end else begin
                w_drop = 1'b1;
            end
        end

        if (w_drop) begin
            w_overflow_d = 1'b1;
        end else if (clear_overflow) begin
            w_overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q     <= ST_IDLE;
            r_work_q      <= '0;
            r_pend_q      <= '0;
            r_pend_vld_q  <= 1'b0;
            r_idx_q       <= '0;
            r_acc_q       <= '0;
            r_out_sum_q   <= '0;
            r_out_valid_q <= 1'b0;
            r_overflow_q  <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_work_q      <= w_work_d;
            r_pend_q      <= w_pend_d;
            r_pend_vld_q  <= w_pend_vld_d;
            r_idx_q       <= w_idx_d;
            r_acc_q       <= w_acc_d;
            r_out_sum_q   <= w_out_sum_d;
            r_out_valid_q <= w_out_valid_d;
            r_overflow_q  <= w_overflow_d;
        end
    end

    assign out_sum   = r_out_sum_q;
    assign out_valid = r_out_valid_q;
    assign overflow  = r_overflow_q;
    assign busy      = (r_state_q != ST_IDLE) || r_pend_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_dot_reducer.sv
`default_nettype none
// ============================================================================
// Module  : tb_vector_dot_reducer
// Brief   : Self-checking bench for vector_dot_reducer against a transaction
//           level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vector_dot_reducer;

    localparam int VS = 8;
    localparam int DW = 16;
    localparam int AW = 19;
    localparam int VW = VS * DW;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [VW-1:0] in_vector;
    logic [AW-1:0] out_sum;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          overflow;
    logic          clear_overflow;

    vector_dot_reducer #(
        .VECTOR_SIZE (VS),
        .DATA_WIDTH  (DW),
        .ACC_WIDTH   (AW)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_vector      (in_vector),
        .out_sum        (out_sum),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a result is "in flight" for VS edges after capture,
    // then held until accepted; pending is a bounded queue of one.
    logic          m_hold;
    int            m_cnt;
    logic [AW-1:0] m_cur;
    logic [AW-1:0] m_out_sum;
    logic          m_ovf;
    logic [VW-1:0] m_pend[$];

    typedef struct {
        logic [VW-1:0] vec;
        logic [AW-1:0] exp_sum;
    } vec_rec_t;

    vec_rec_t table_q[$];

    function automatic logic [VW-1:0] make_vec(input int base, input int step);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < VS; i++) begin
            v[i*DW +: DW] = DW'(base + step * i);
        end
        return v;
    endfunction

    function automatic logic [AW-1:0] ref_sum(input logic [VW-1:0] v);
        longint s;
        s = 0;
        for (int i = 0; i < VS; i++) begin
            s += longint'(v[i*DW +: DW]);
        end
        return s[AW-1:0];
    endfunction

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold    = 1'b0;
        m_cnt     = 0;
        m_cur     = '0;
        m_out_sum = '0;
        m_ovf     = 1'b0;
        m_pend.delete();
    endtask

    task automatic model_start(input logic [VW-1:0] v);
        m_cur = ref_sum(v);
        m_cnt = VS;
    endtask

    task automatic model_step(input logic iv, input logic [VW-1:0] vec,
                              input logic rdy, input logic clr);
        logic park;
        logic drop;
        park = 1'b0;
        drop = 1'b0;
        if (m_hold) begin
            if (rdy) begin
                m_hold = 1'b0;
                if (m_pend.size() > 0) begin
                    model_start(m_pend.pop_front());
                    if (iv) m_pend.push_back(vec);
                end else if (iv) begin
                    model_start(vec);
                end
            end else begin
                park = iv;
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_hold    = 1'b1;
                m_out_sum = m_cur;
            end
            park = iv;
        end else if (iv) begin
            model_start(vec);
        end
        if (park) begin
            if (m_pend.size() == 0) m_pend.push_back(vec);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic check_outputs();
        check("out_valid", VW'(out_valid), VW'(m_hold));
        check("out_sum",   VW'(out_sum),   VW'(m_out_sum));
        check("busy",      VW'(busy),      VW'(m_hold || (m_cnt > 0) || (m_pend.size() > 0)));
        check("overflow",  VW'(overflow),  VW'(m_ovf));
    endtask

    // Inputs are driven 1 time unit after an edge and sampled 1 unit after the next.
    task automatic tick(input logic iv, input logic [VW-1:0] vec,
                        input logic rdy, input logic clr);
        in_valid       = iv;
        in_vector      = vec;
        out_ready      = rdy;
        clear_overflow = clr;
        @(posedge clk);
        model_step(iv, vec, rdy, clr);
        #1;
        check_outputs();
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, rdy, 1'b0);
    endtask

    task automatic wait_result(output logic [AW-1:0] s, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick(1'b0, '0, 1'b0, 1'b0);
            lat++;
        end
        check("result_arrives", VW'(out_valid), VW'(1'b1));
        s = out_sum;
    endtask

    logic [VW-1:0] v_ramp, v_two, v_three, v_ffff;
    logic [AW-1:0] got_sum;
    int            got_lat;
    int            seen;

    initial begin
        v_ramp  = make_vec(1, 1);
        v_two   = make_vec(2, 0);
        v_three = make_vec(3, 0);
        v_ffff  = make_vec(16'hFFFF, 0);

        table_q.push_back('{v_ramp,                   19'd36});
        table_q.push_back('{v_ffff,                   19'h7FFF8});
        table_q.push_back('{v_two,                    19'd16});
        table_q.push_back('{v_three,                  19'd24});
        table_q.push_back('{make_vec(0, 0),           19'd0});
        table_q.push_back('{make_vec(16'h1000, 16'h1000), 19'd147456});

        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_vector      = '0;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, '0, 1'b1, 1'b0);

        // Table-driven single vectors with out_ready held high.
        for (int r = 0; r < table_q.size(); r++) begin
            tick(1'b1, table_q[r].vec, 1'b1, 1'b0);
            got_lat = 0;
            while (!out_valid && got_lat < 40) begin
                tick(1'b0, '0, 1'b1, 1'b0);
                got_lat++;
            end
            check("table_sum", VW'(out_sum), VW'(table_q[r].exp_sum));
            check("table_latency", VW'(got_lat), VW'(VS));
            tick(1'b0, '0, 1'b1, 1'b0);
            check("table_valid_one_cycle", VW'(out_valid), VW'(1'b0));
            check("table_busy_drop", VW'(busy), VW'(1'b0));
        end

        // Stall: second vector parks, third is dropped.
        tick(1'b1, v_ramp, 1'b0, 1'b0);
        wait_result(got_sum, got_lat);
        check("stall_first_sum", VW'(got_sum), VW'(19'd36));
        for (int i = 0; i < 20; i++) begin
            tick(i == 2, (i == 2) ? v_two : v_three, 1'b0, 1'b0);
            if (i == 5) tick(1'b1, v_three, 1'b0, 1'b0);
            check("stall_sum_stable", VW'(out_sum), VW'(19'd36));
        end
        check("stall_overflow", VW'(overflow), VW'(1'b1));
        tick(1'b0, '0, 1'b1, 1'b0);
        wait_result(got_sum, got_lat);
        check("stall_second_sum", VW'(got_sum), VW'(19'd16));
        check("stall_second_latency", VW'(got_lat), VW'(VS));
        tick(1'b0, '0, 1'b1, 1'b0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1'b0, '0, 1'b1, 1'b0);
            if (out_valid) seen++;
        end
        check("stall_third_never", VW'(seen), VW'(0));
        tick(1'b0, '0, 1'b0, 1'b1);
        check("clear_alone", VW'(overflow), VW'(1'b0));

        // Handshake with pending full and a same-cycle arrival: nothing dropped.
        tick(1'b1, v_ramp, 1'b0, 1'b0);
        tick(1'b1, v_two, 1'b0, 1'b0);
        wait_result(got_sum, got_lat);
        tick(1'b1, v_three, 1'b1, 1'b0);
        check("simul_no_drop", VW'(overflow), VW'(1'b0));
        wait_result(got_sum, got_lat);
        check("simul_pending_sum", VW'(got_sum), VW'(19'd16));
        tick(1'b0, '0, 1'b1, 1'b0);
        wait_result(got_sum, got_lat);
        check("simul_new_sum", VW'(got_sum), VW'(19'd24));
        check("simul_new_latency", VW'(got_lat), VW'(VS));
        tick(1'b0, '0, 1'b1, 1'b0);
        check("simul_overflow_still0", VW'(overflow), VW'(1'b0));

        // Clear coinciding with a drop: set wins.
        tick(1'b1, v_ramp, 1'b0, 1'b0);
        tick(1'b1, v_two, 1'b0, 1'b0);
        tick(1'b1, v_three, 1'b0, 1'b0);
        tick(1'b1, v_two, 1'b0, 1'b1);
        check("clear_vs_drop", VW'(overflow), VW'(1'b1));
        tick(1'b0, '0, 1'b0, 1'b1);
        check("clear_after", VW'(overflow), VW'(1'b0));
        idle(1'b1, 30);

        // Asynchronous reset in the middle of a reduction.
        tick(1'b1, v_ramp, 1'b0, 1'b0);
        idle(1'b0, 4);
        tick(1'b1, v_two, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_out_sum", VW'(out_sum), VW'(0));
        check("rst_out_valid", VW'(out_valid), VW'(0));
        check("rst_busy", VW'(busy), VW'(0));
        check("rst_overflow", VW'(overflow), VW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, '0, 1'b1, 1'b0);
        tick(1'b1, v_ramp, 1'b0, 1'b0);
        wait_result(got_sum, got_lat);
        check("post_rst_sum", VW'(got_sum), VW'(19'd36));
        check("post_rst_latency", VW'(got_lat), VW'(VS));
        tick(1'b0, '0, 1'b1, 1'b0);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [VW-1:0] rv;
            for (int w = 0; w < VW / 32; w++) rv[w*32 +: 32] = $urandom;
            if ($urandom_range(0, 3) == 0) rv = make_vec(16'hFFFF, 0);
            tick($urandom_range(0, 5) == 0, rv, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 19) == 0);
        end
        idle(1'b1, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
